// File: rtl/unidade_controle_rodadas_pkg.sv
// unidade_controle_rodadas_pkg
// Shared definitions for the round controller of the memory game:
//   - 4-bit state codes, which are also what the db_estado hex display shows
//   - default inactivity budget (3 s at the 1 kHz board clock)
//   - packed bundle of the Moore outputs and the decode from a state code
package unidade_controle_rodadas_pkg;

  typedef logic [3:0] estado_t;

  localparam estado_t ST_INICIAL     = 4'h0;
  localparam estado_t ST_PREPARA     = 4'h1;
  localparam estado_t ST_NOVA_RODADA = 4'h2;
  localparam estado_t ST_ESPERA      = 4'h3;
  localparam estado_t ST_REGISTRA    = 4'h4;
  localparam estado_t ST_COMPARA     = 4'h5;
  localparam estado_t ST_PROX_JOGADA = 4'h6;
  localparam estado_t ST_PROX_RODADA = 4'h7;
  localparam estado_t ST_FIM_ACERTO  = 4'hA;
  localparam estado_t ST_FIM_TIMEOUT = 4'hD;
  localparam estado_t ST_FIM_ERRO    = 4'hE;

  localparam int TIMEOUT_CYCLES_DEFAULT = 3000;

  // Every control and status output of the FSM, in one packed word
  typedef struct packed {
    logic zeraE;
    logic contaE;
    logic zeraL;
    logic contaL;
    logic zeraR;
    logic registraR;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  // Moore decode: outputs depend on the state code alone; anything not
  // named for a state stays 0, including unused codes
  function automatic saidas_t decodifica_saidas(input estado_t estado);
    saidas_t s;
    s = '0;
    case (estado)
      ST_PREPARA: begin
        s.zeraE = 1'b1;
        s.zeraL = 1'b1;
        s.zeraR = 1'b1;
      end
      ST_NOVA_RODADA: s.zeraE     = 1'b1;
      ST_REGISTRA:    s.registraR = 1'b1;
      ST_PROX_JOGADA: s.contaE    = 1'b1;
      ST_PROX_RODADA: s.contaL    = 1'b1;
      ST_FIM_ACERTO: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      ST_FIM_ERRO: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      ST_FIM_TIMEOUT: begin
        s.pronto  = 1'b1;
        s.timeout = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  // The three game-over states share the same restart behaviour
  function automatic logic estado_final(input estado_t estado);
    return (estado == ST_FIM_ACERTO) || (estado == ST_FIM_ERRO) ||
           (estado == ST_FIM_TIMEOUT);
  endfunction

endpackage

// File: rtl/unidade_controle_rodadas_contador_timeout.sv
// contador_timeout
// Inactivity up-counter used while the controller waits for a move.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-low
//   zera   - synchronous clear (has priority over conta)
//   conta  - increment by one; saturates at LIMITE-1, never wraps
//   valor  - current count
//   fim    - terminal count, valor == LIMITE-1
module contador_timeout #(
  parameter int LIMITE = 3000,
  parameter int W      = $clog2(LIMITE)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] valor,
  output logic         fim
);

  localparam logic [W-1:0] ULTIMO = W'(LIMITE - 1);

  logic [W-1:0] valor_q;
  logic [W-1:0] valor_d;

  // Clear wins over count; holding at the terminal value keeps the
  // counter from wrapping back into a fresh budget
  always_comb begin
    valor_d = valor_q;
    if (zera) begin
      valor_d = '0;
    end else if (conta && !fim) begin
      valor_d = valor_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign fim   = (valor_q == ULTIMO);
  assign valor = valor_q;

endmodule

// File: rtl/unidade_controle_rodadas.sv
// unidade_controle_rodadas
// Moore control unit for the round-based memory game. It sequences the
// play-address counter (E), the round-limit counter (L), the play register
// (R) and watches the comparator, ending the game on a hit of the last
// round, a miss, or a player who stays idle too long.
// Ports:
//   clock, reset            - system clock; asynchronous active-low reset
//   iniciar                 - start/restart request (level)
//   jogada                  - one-cycle pulse: a new key press is available
//   igual                   - comparator: play == memory word
//   fim_endereco            - play address reached the current round limit
//   fim_limite              - round limit reached the last round
//   zeraE/contaE            - clear / increment play-address counter
//   zeraL/contaL            - clear / increment round-limit counter
//   zeraR/registraR         - clear / load play register
//   pronto/acertou/errou/timeout - game-over status
//   db_estado               - current state code for the hex display
//   db_timer                - current inactivity timer value
module unidade_controle_rodadas
  import unidade_controle_rodadas_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic             jogada,
  input  logic             igual,
  input  logic             fim_endereco,
  input  logic             fim_limite,
  output logic             zeraE,
  output logic             contaE,
  output logic             zeraL,
  output logic             contaL,
  output logic             zeraR,
  output logic             registraR,
  output logic             pronto,
  output logic             acertou,
  output logic             errou,
  output logic             timeout,
  output logic [3:0]       db_estado,
  output logic [TMR_W-1:0] db_timer
);

  estado_t    estado_q;
  estado_t    estado_d;
  saidas_t    saidas;
  logic       timer_zera;
  logic       timer_conta;
  logic       timer_fim;

  // The timer only runs while we stay in ESPERA; every entry into ESPERA
  // and every other state sees it cleared, so each move gets a full budget
  assign timer_conta = (estado_q == ST_ESPERA) && (estado_d == ST_ESPERA);
  assign timer_zera  = !timer_conta;

  contador_timeout #(
    .LIMITE (TIMEOUT_CYCLES),
    .W      (TMR_W)
  ) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (timer_zera),
    .conta (timer_conta),
    .valor (db_timer),
    .fim   (timer_fim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= ST_INICIAL;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic. A move in the same cycle as the terminal count is
  // taken as a move, not a timeout
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ST_INICIAL: begin
        if (iniciar) estado_d = ST_PREPARA;
      end
      ST_PREPARA:     estado_d = ST_NOVA_RODADA;
      ST_NOVA_RODADA: estado_d = ST_ESPERA;
      ST_ESPERA: begin
        if (jogada) begin
          estado_d = ST_REGISTRA;
        end else if (timer_fim) begin
          estado_d = ST_FIM_TIMEOUT;
        end
      end
      ST_REGISTRA: estado_d = ST_COMPARA;
      ST_COMPARA: begin
        if (!igual) begin
          estado_d = ST_FIM_ERRO;
        end else if (!fim_endereco) begin
          estado_d = ST_PROX_JOGADA;
        end else if (!fim_limite) begin
          estado_d = ST_PROX_RODADA;
        end else begin
          estado_d = ST_FIM_ACERTO;
        end
      end
      ST_PROX_JOGADA: estado_d = ST_ESPERA;
      ST_PROX_RODADA: estado_d = ST_NOVA_RODADA;
      ST_FIM_ACERTO, ST_FIM_ERRO, ST_FIM_TIMEOUT: begin
        if (iniciar) estado_d = ST_PREPARA;
      end
      default: estado_d = ST_INICIAL;
    endcase
  end

  assign saidas    = decodifica_saidas(estado_q);
  assign zeraE     = saidas.zeraE;
  assign contaE    = saidas.contaE;
  assign zeraL     = saidas.zeraL;
  assign contaL    = saidas.contaL;
  assign zeraR     = saidas.zeraR;
  assign registraR = saidas.registraR;
  assign pronto    = saidas.pronto;
  assign acertou   = saidas.acertou;
  assign errou     = saidas.errou;
  assign timeout   = saidas.timeout;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// tb_unidade_controle_rodadas
// Directed bench for the round controller: reset, start, round and move
// progression, timeout, move on the terminal cycle, miss, win, restart
// and an asynchronous reset in the middle of a wait.
module tb_unidade_controle_rodadas;

  localparam int TMO = 3000;
  localparam int TW  = $clog2(TMO);

  // Output word order: zeraE contaE zeraL contaL zeraR registraR
  //                    pronto acertou errou timeout
  localparam logic [9:0] OUT_NONE     = 10'b0000000000;
  localparam logic [9:0] OUT_PREPARA  = 10'b1010100000;
  localparam logic [9:0] OUT_NOVA     = 10'b1000000000;
  localparam logic [9:0] OUT_REGISTRA = 10'b0000010000;
  localparam logic [9:0] OUT_PROXJ    = 10'b0100000000;
  localparam logic [9:0] OUT_PROXR    = 10'b0001000000;
  localparam logic [9:0] OUT_ACERTO   = 10'b0000001100;
  localparam logic [9:0] OUT_ERRO     = 10'b0000001010;
  localparam logic [9:0] OUT_TIMEOUT  = 10'b0000001001;

  logic          clock;
  logic          reset;
  logic          iniciar;
  logic          jogada;
  logic          igual;
  logic          fimEndereco;
  logic          fimLimite;
  logic          zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic          pronto, acertou, errou, timeout;
  logic [3:0]    dbEstado;
  logic [TW-1:0] dbTimer;
  logic [9:0]    saidas;

  int testsRun;
  int testsFailed;

  unidade_controle_rodadas #(
    .TIMEOUT_CYCLES (TMO),
    .TMR_W          (TW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .jogada       (jogada),
    .igual        (igual),
    .fim_endereco (fimEndereco),
    .fim_limite   (fimLimite),
    .zeraE        (zeraE),
    .contaE       (contaE),
    .zeraL        (zeraL),
    .contaL       (contaL),
    .zeraR        (zeraR),
    .registraR    (registraR),
    .pronto       (pronto),
    .acertou      (acertou),
    .errou        (errou),
    .timeout      (timeout),
    .db_estado    (dbEstado),
    .db_timer     (dbTimer)
  );

  assign saidas = {zeraE, contaE, zeraL, contaL, zeraR, registraR,
                   pronto, acertou, errou, timeout};

  // 10-unit clock period
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic ini, input logic jog, input logic igu,
                               input logic fe, input logic fl);
    iniciar     = ini;
    jogada      = jog;
    igual       = igu;
    fimEndereco = fe;
    fimLimite   = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);

    // Reset held low
    repeat (3) tick();
    checkOutput("rst_estado", 32'(dbEstado), 32'h0);
    checkOutput("rst_saidas", 32'(saidas), 32'(OUT_NONE));
    checkOutput("rst_timer", 32'(dbTimer), 32'd0);

    // Release reset; idle without iniciar stays in INICIAL
    reset = 1'b1;
    tick();
    checkOutput("idle_estado", 32'(dbEstado), 32'h0);

    // Start: 1, 2, 3 on successive edges
    applyStimulus(1, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("start_prepara", 32'(dbEstado), 32'h1);
    checkOutput("start_prepara_out", 32'(saidas), 32'(OUT_PREPARA));
    tick();
    checkOutput("start_nova", 32'(dbEstado), 32'h2);
    checkOutput("start_nova_out", 32'(saidas), 32'(OUT_NOVA));
    tick();
    checkOutput("start_espera", 32'(dbEstado), 32'h3);
    checkOutput("start_espera_out", 32'(saidas), 32'(OUT_NONE));
    checkOutput("start_timer0", 32'(dbTimer), 32'd0);

    // iniciar is ignored in ESPERA; timer counts
    applyStimulus(1, 0, 0, 0, 0);
    tick();
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("espera_ign_ini", 32'(dbEstado), 32'h3);
    checkOutput("espera_timer2", 32'(dbTimer), 32'd2);

    // Round 1 correct: 4, 5, 7, 2, 3
    applyStimulus(0, 1, 1, 1, 0);
    tick();
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("r1_registra", 32'(dbEstado), 32'h4);
    checkOutput("r1_registra_out", 32'(saidas), 32'(OUT_REGISTRA));
    checkOutput("r1_registra_tmr", 32'(dbTimer), 32'd0);
    tick();
    checkOutput("r1_compara", 32'(dbEstado), 32'h5);
    checkOutput("r1_compara_out", 32'(saidas), 32'(OUT_NONE));
    tick();
    checkOutput("r1_proxrodada", 32'(dbEstado), 32'h7);
    checkOutput("r1_contaL", 32'(saidas), 32'(OUT_PROXR));
    tick();
    checkOutput("r1_nova", 32'(dbEstado), 32'h2);
    checkOutput("r1_contaL_off", 32'(saidas), 32'(OUT_NOVA));
    tick();
    checkOutput("r1_espera", 32'(dbEstado), 32'h3);
    checkOutput("r1_timer0", 32'(dbTimer), 32'd0);

    // Mid-round correct: 4, 5, 6, 3 with timer restart
    repeat (5) tick();
    checkOutput("mid_timer5", 32'(dbTimer), 32'd5);
    applyStimulus(0, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("mid_registra", 32'(dbEstado), 32'h4);
    tick();
    checkOutput("mid_compara", 32'(dbEstado), 32'h5);
    tick();
    checkOutput("mid_proxjogada", 32'(dbEstado), 32'h6);
    checkOutput("mid_contaE", 32'(saidas), 32'(OUT_PROXJ));
    tick();
    checkOutput("mid_espera", 32'(dbEstado), 32'h3);
    checkOutput("mid_contaE_off", 32'(saidas), 32'(OUT_NONE));
    checkOutput("mid_timer0", 32'(dbTimer), 32'd0);

    // Timeout after 3000 idle ESPERA cycles
    applyStimulus(0, 0, 0, 0, 0);
    repeat (TMO - 1) tick();
    checkOutput("tmo_last_espera", 32'(dbEstado), 32'h3);
    checkOutput("tmo_last_timer", 32'(dbTimer), 32'(TMO - 1));
    tick();
    checkOutput("tmo_estado", 32'(dbEstado), 32'hD);
    checkOutput("tmo_out", 32'(saidas), 32'(OUT_TIMEOUT));
    checkOutput("tmo_timer0", 32'(dbTimer), 32'd0);
    applyStimulus(0, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("tmo_hold", 32'(dbEstado), 32'hD);

    // Restart clears the status flags
    applyStimulus(1, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("restart1_estado", 32'(dbEstado), 32'h1);
    checkOutput("restart1_out", 32'(saidas), 32'(OUT_PREPARA));
    tick();
    tick();
    checkOutput("restart1_espera", 32'(dbEstado), 32'h3);

    // Move on the 3000th cycle wins over the timeout, then a miss
    repeat (TMO - 1) tick();
    checkOutput("edge_timer", 32'(dbTimer), 32'(TMO - 1));
    applyStimulus(0, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("edge_registra", 32'(dbEstado), 32'h4);
    checkOutput("edge_no_timeout", 32'(saidas), 32'(OUT_REGISTRA));
    tick();
    tick();
    checkOutput("miss_estado", 32'(dbEstado), 32'hE);
    checkOutput("miss_out", 32'(saidas), 32'(OUT_ERRO));

    // Miss, then restart clears errou
    applyStimulus(1, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("restart2_estado", 32'(dbEstado), 32'h1);
    checkOutput("restart2_out", 32'(saidas), 32'(OUT_PREPARA));
    tick();
    tick();

    // Win: all three comparator flags set
    applyStimulus(0, 1, 1, 1, 1);
    tick();
    applyStimulus(0, 0, 1, 1, 1);
    tick();
    tick();
    checkOutput("win_estado", 32'(dbEstado), 32'hA);
    checkOutput("win_out", 32'(saidas), 32'(OUT_ACERTO));
    applyStimulus(0, 0, 0, 0, 0);
    tick();
    checkOutput("win_hold", 32'(dbEstado), 32'hA);

    // Reset mid-wait is immediate, not at the next edge
    applyStimulus(1, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    tick();
    tick();
    repeat (1500) tick();
    checkOutput("midrst_timer", 32'(dbTimer), 32'd1500);
    reset = 1'b0;
    #1;
    checkOutput("midrst_estado", 32'(dbEstado), 32'h0);
    checkOutput("midrst_timer0", 32'(dbTimer), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("midrst_idle", 32'(dbEstado), 32'h0);

    // After restart the timeout still needs the full budget
    applyStimulus(1, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("full_espera", 32'(dbEstado), 32'h3);
    repeat (TMO - 1) tick();
    checkOutput("full_last_espera", 32'(dbEstado), 32'h3);
    tick();
    checkOutput("full_timeout", 32'(dbEstado), 32'hD);
    checkOutput("full_timeout_out", 32'(saidas), 32'(OUT_TIMEOUT));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
